alu_input_sequencer: RTL and testbench
======================================

Name: alu_input_sequencer

Overview:
- Front-end stage that feeds the ALU on the board.
- Takes the shared slide switches and one push-button. Debounces the button, then steps through three loads: operand A, operand B, opcode.
- Presents registered DATOA / DATOB / OPCODE straight to the ALU ports, plus VALID once a full operand set is held.
- Makes the ALU usable from SWITCHES plus a single LOAD button.

Parameters:
- SIZEDATA, 8, operand width; matches ALU DATOA/DATOB/RESULT.
- SIZEOP, 6, opcode width; matches ALU OPCODE; must satisfy SIZEOP <= SIZEDATA.
- DEBOUNCE_CYCLES, 100000, consecutive stable cycles required before a button level change is accepted; minimum 2.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- SWITCHES  in  SIZEDATA  raw switch bank; quasi-static, not synchronised.
- BTN_LOAD  in  1  raw, asynchronous, bouncy push-button; active-high.
- DATOA  out  SIZEDATA  operand A register to ALU.
- DATOB  out  SIZEDATA  operand B register to ALU.
- OPCODE  out  SIZEOP  opcode register to ALU.
- VALID  out  1  high while A, B and OPCODE all belong to one completed sequence.
- STATE  out  2  current FSM state, for LEDs: 00 LOAD_A, 01 LOAD_B, 10 LOAD_OP, 11 DONE.

Behaviour:
- Reset (async, active-high):
  - DATOA = 0, DATOB = 0, OPCODE = 0, VALID = 0, STATE = LOAD_A.
  - Synchroniser flops = 0, debounced level = 0, debounce counter = 0.
  - Reset asserted mid-sequence or mid-debounce aborts immediately. No load occurs while RESET is high.
- Synchroniser: BTN_LOAD passes through 2 flops to give BTN_SYNC.
- Debounce:
  - If BTN_SYNC equals DB_LEVEL, counter clears.
  - Otherwise the counter increments each cycle. When it reaches DEBOUNCE_CYCLES-1 while still differing, DB_LEVEL takes BTN_SYNC and the counter clears.
  - Any return to DB_LEVEL before that point clears the counter, so glitches shorter than DEBOUNCE_CYCLES are ignored.
- Press detection:
  - PRESS is a single-cycle pulse on the DB_LEVEL rising edge (DB_LEVEL & ~DB_LEVEL_d1).
  - Release is debounced but generates no event.
  - Holding the button produces exactly one PRESS.
- Latency: with BTN_LOAD high and clean from clock edge k, the target register and STATE update at edge k+DEBOUNCE_CYCLES+3.
- FSM, acting only on PRESS; with no PRESS all registers hold:
  - LOAD_A: DATOA <= SWITCHES; go to LOAD_B.
  - LOAD_B: DATOB <= SWITCHES; go to LOAD_OP.
  - LOAD_OP: OPCODE <= SWITCHES[SIZEOP-1:0] (upper switch bits ignored); VALID <= 1; go to DONE.
  - DONE: DATOA <= SWITCHES; VALID <= 0; go to LOAD_B. This starts a new sequence in one press, with no idle press.
- VALID:
  - Registered; changes on the same edge as the state transition.
  - Never high while any operand is stale relative to the current sequence.
- Outputs are all registered and glitch-free; SWITCHES changes never alter outputs outside a PRESS cycle.
- Operand registers are plain bit vectors. Signedness is interpreted by the ALU only; no extension or truncation beyond the OPCODE slice.

Test Plan (bench uses DEBOUNCE_CYCLES = 4):
- Reset then idle 20 cycles -> DATOA = DATOB = 0, OPCODE = 0, VALID = 0, STATE = 00.
- SWITCHES = 200, clean press held 12 cycles -> DATOA = 200 (0xC8) exactly 7 edges after press start; STATE = 01; DATOB unchanged.
- Full sequence: 4 / press, 1 / press, SWITCHES = 8'b00100000 / press -> DATOA = 4, DATOB = 1, OPCODE = 6'b100000, VALID = 1, STATE = 11; downstream ALU RESULT = 5, CARRY = 0.
- Bounce: BTN_LOAD toggles 1,0,1,0 each cycle for 8 cycles, then held high 10 cycles -> exactly one load, STATE advances by one. A lone 3-cycle high pulse -> no load.
- From DONE, SWITCHES = 8, press -> DATOA = 8, VALID = 0, STATE = 01; DATOB and OPCODE retain old values.
- Assert RESET for 1 cycle during debounce count (count = 2) in LOAD_OP -> all outputs zero immediately, STATE = 00; button still held after reset produces one new PRESS and a DATOA load.

Source files
------------

// File: rtl/alu_input_sequencer.sv
// Front end for the board ALU: synchronises and debounces one LOAD button, then
// steps switch values into operand A, operand B and the opcode, flagging VALID.
module alu_input_sequencer #(
    parameter int SIZEDATA        = 8,
    parameter int SIZEOP          = 6,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [SIZEDATA-1:0] SWITCHES,
    input  logic                BTN_LOAD,
    output logic [SIZEDATA-1:0] DATOA,
    output logic [SIZEDATA-1:0] DATOB,
    output logic [SIZEOP-1:0]   OPCODE,
    output logic                VALID,
    output logic [1:0]          STATE
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        LOAD_A  = 2'b00,
        LOAD_B  = 2'b01,
        LOAD_OP = 2'b10,
        DONE    = 2'b11
    } state_t;

    logic [1:0]          sync_r;
    logic                btn_sync_s;
    logic                db_level_r;
    logic                db_level_d1_r;
    logic [CNT_W-1:0]    db_cnt_r;
    logic                press_r;

    state_t              state_r, state_s;
    logic [SIZEDATA-1:0] datoa_r, datoa_s;
    logic [SIZEDATA-1:0] datob_r, datob_s;
    logic [SIZEOP-1:0]   opcode_r, opcode_s;
    logic                valid_r, valid_s;

    assign btn_sync_s = sync_r[1];

    // Two-flop synchroniser for the raw button.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], BTN_LOAD};
        end
    end

    // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            db_level_r <= 1'b0;
            db_cnt_r   <= '0;
        end else if (btn_sync_s == db_level_r) begin
            db_cnt_r   <= '0;
        end else if (db_cnt_r == CNT_MAX) begin
            db_level_r <= btn_sync_s;
            db_cnt_r   <= '0;
        end else begin
            db_cnt_r   <= db_cnt_r + CNT_ONE;
        end
    end

    // Registered one-cycle press pulse on the debounced rising edge; release is silent.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            db_level_d1_r <= 1'b0;
            press_r       <= 1'b0;
        end else begin
            db_level_d1_r <= db_level_r;
            press_r       <= db_level_r & ~db_level_d1_r;
        end
    end

    // Load sequencer next-state and register values; everything holds without a press.
    always_comb begin
        state_s  = state_r;
        datoa_s  = datoa_r;
        datob_s  = datob_r;
        opcode_s = opcode_r;
        valid_s  = valid_r;
        if (press_r) begin
            case (state_r)
                LOAD_A: begin
                    datoa_s = SWITCHES;
                    state_s = LOAD_B;
                end
                LOAD_B: begin
                    datob_s = SWITCHES;
                    state_s = LOAD_OP;
                end
                LOAD_OP: begin
                    opcode_s = SWITCHES[SIZEOP-1:0];
                    valid_s  = 1'b1;
                    state_s  = DONE;
                end
                DONE: begin
                    // A press here begins the next set directly with operand A.
                    datoa_s = SWITCHES;
                    valid_s = 1'b0;
                    state_s = LOAD_B;
                end
                default: begin
                    valid_s = 1'b0;
                    state_s = LOAD_A;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Sequencer state and ALU-facing output registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r  <= LOAD_A;
            datoa_r  <= '0;
            datob_r  <= '0;
            opcode_r <= '0;
            valid_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            datoa_r  <= datoa_s;
            datob_r  <= datob_s;
            opcode_r <= opcode_s;
            valid_r  <= valid_s;
        end
    end

    assign DATOA  = datoa_r;
    assign DATOB  = datob_r;
    assign OPCODE = opcode_r;
    assign VALID  = valid_r;
    assign STATE  = state_r;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Self-checking bench for alu_input_sequencer with a short debounce window.
module tb_alu_input_sequencer;

    localparam int SD = 8;
    localparam int SO = 6;
    localparam int DB = 4;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [SD-1:0] SWITCHES;
    logic          BTN_LOAD;
    logic [SD-1:0] DATOA;
    logic [SD-1:0] DATOB;
    logic [SO-1:0] OPCODE;
    logic          VALID;
    logic [1:0]    STATE;

    typedef struct {
        logic [SD-1:0] sw;
        logic [SD-1:0] a;
        logic [SD-1:0] b;
        logic [SO-1:0] op;
        logic          v;
        logic [1:0]    st;
    } vec_t;

    vec_t vecs[6];
    vec_t sb_q[$];
    vec_t zero_v;
    int   checks = 0;
    int   errors = 0;

    alu_input_sequencer #(
        .SIZEDATA(SD), .SIZEOP(SO), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .CLK(CLK), .RESET(RESET), .SWITCHES(SWITCHES), .BTN_LOAD(BTN_LOAD),
        .DATOA(DATOA), .DATOB(DATOB), .OPCODE(OPCODE), .VALID(VALID), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input vec_t e);
        chk({tag, ".datoa"},  32'(DATOA),  32'(e.a));
        chk({tag, ".datob"},  32'(DATOB),  32'(e.b));
        chk({tag, ".opcode"}, 32'(OPCODE), 32'(e.op));
        chk({tag, ".valid"},  32'(VALID),  32'(e.v));
        chk({tag, ".state"},  32'(STATE),  32'(e.st));
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Push the expected record, press, wait (bounded) for the load, pop and compare.
    task automatic press_sb(input string tag, input vec_t v);
        vec_t       e;
        logic [1:0] st0;
        logic       seen;
        st0  = STATE;
        seen = 1'b0;
        SWITCHES = v.sw;
        sb_q.push_back(v);
        BTN_LOAD = 1'b1;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge CLK);
            if (STATE !== st0) seen = 1'b1;
        end
        e = sb_q.pop_front();
        chk({tag, ".load_seen"}, 32'(seen), 32'd1);
        chk_out(tag, e);
        // Switch changes and a long hold must not disturb the outputs.
        SWITCHES = ~v.sw;
        wait_cycles(3);
        BTN_LOAD = 1'b0;
        wait_cycles(12);
        chk_out({tag, ".after"}, e);
    endtask

    initial begin
        logic [SD:0] alu_sum;
        logic        seen;

        vecs[0] = '{sw: 8'd4,   a: 8'd4, b: 8'd0,   op: 6'd0,      v: 1'b0, st: 2'd1};
        vecs[1] = '{sw: 8'd1,   a: 8'd4, b: 8'd1,   op: 6'd0,      v: 1'b0, st: 2'd2};
        vecs[2] = '{sw: 8'h20,  a: 8'd4, b: 8'd1,   op: 6'b100000, v: 1'b1, st: 2'd3};
        vecs[3] = '{sw: 8'd8,   a: 8'd8, b: 8'd1,   op: 6'b100000, v: 1'b0, st: 2'd1};
        vecs[4] = '{sw: 8'hFF,  a: 8'd8, b: 8'hFF,  op: 6'b100000, v: 1'b0, st: 2'd2};
        vecs[5] = '{sw: 8'hE7,  a: 8'd8, b: 8'hFF,  op: 6'h27,     v: 1'b1, st: 2'd3};
        zero_v  = '{sw: 8'd0,   a: 8'd0, b: 8'd0,   op: 6'd0,      v: 1'b0, st: 2'd0};

        // Reset and idle.
        RESET = 1'b1; BTN_LOAD = 1'b0; SWITCHES = 8'd0;
        wait_cycles(3);
        chk_out("in_reset", zero_v);
        RESET = 1'b0;
        wait_cycles(20);
        chk_out("idle", zero_v);

        // Exact latency: button first sampled high at edge k, load at edge k+7.
        SWITCHES = 8'd200;
        BTN_LOAD = 1'b1;
        wait_cycles(7);
        chk("lat_early.datoa", 32'(DATOA), 32'd0);
        chk("lat_early.state", 32'(STATE), 32'd0);
        wait_cycles(1);
        chk("lat_exact.datoa", 32'(DATOA), 32'd200);
        chk("lat_exact.state", 32'(STATE), 32'd1);
        chk("lat_exact.datob", 32'(DATOB), 32'd0);
        wait_cycles(4);
        BTN_LOAD = 1'b0;
        wait_cycles(12);

        // Fresh start, then the table of full sequences.
        RESET = 1'b1;
        wait_cycles(2);
        RESET = 1'b0;
        wait_cycles(2);
        for (int i = 0; i < 6; i++) begin
            press_sb($sformatf("vec%0d", i), vecs[i]);
            if (i == 2) begin
                alu_sum = {1'b0, DATOA} + {1'b0, DATOB};
                chk("alu.result", 32'(alu_sum[SD-1:0]), 32'd5);
                chk("alu.carry",  32'(alu_sum[SD]),     32'd0);
            end
        end

        // Bouncy press from DONE: toggling must not load, the settled hold loads once.
        SWITCHES = 8'h11;
        for (int i = 0; i < 8; i++) begin
            BTN_LOAD = (i % 2 == 0) ? 1'b1 : 1'b0;
            @(negedge CLK);
        end
        chk("bounce.no_load", 32'(STATE), 32'd3);
        BTN_LOAD = 1'b1;
        wait_cycles(10);
        chk_out("bounce", '{sw: 8'h11, a: 8'h11, b: 8'hFF, op: 6'h27, v: 1'b0, st: 2'd1});
        BTN_LOAD = 1'b0;
        wait_cycles(12);

        // A lone 3-cycle pulse is shorter than the debounce window.
        SWITCHES = 8'h22;
        BTN_LOAD = 1'b1;
        wait_cycles(3);
        BTN_LOAD = 1'b0;
        wait_cycles(15);
        chk("pulse.state", 32'(STATE), 32'd1);
        chk("pulse.datob", 32'(DATOB), 32'hFF);

        // Reach LOAD_OP, then reset in the middle of a debounce count.
        press_sb("to_op", '{sw: 8'h33, a: 8'h11, b: 8'h33, op: 6'h27, v: 1'b0, st: 2'd2});
        SWITCHES = 8'h5A;
        BTN_LOAD = 1'b1;
        wait_cycles(4);
        chk("mid_db.state", 32'(STATE), 32'd2);
        RESET = 1'b1;
        #1;
        chk_out("async_rst", zero_v);
        @(negedge CLK);
        RESET = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge CLK);
            if (STATE !== 2'd0) seen = 1'b1;
        end
        chk("post_rst.load_seen", 32'(seen), 32'd1);
        chk_out("post_rst", '{sw: 8'h5A, a: 8'h5A, b: 8'd0, op: 6'd0, v: 1'b0, st: 2'd1});
        wait_cycles(10);
        chk("post_rst.single", 32'(STATE), 32'd1);
        BTN_LOAD = 1'b0;
        wait_cycles(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
